toggle_rx: RTL and testbench

- Receiving end of a two-phase toggle event interface.
- A sender (T-flip-flop style) flips `req_tgl` once per event. This block detects each flip, queues the events in a saturating pending counter, and presents them one at a time on a valid/ready port.
- Each consumed event is returned to the sender as a flip of `ack_tgl`.
- Sits between a toggle-generating producer and a pulse/handshake consumer in the sequential-circuit library.

---
 rtl/toggle_pkg.sv | 13 +
 rtl/toggle_edge_det.sv | 43 ++++
 rtl/toggle_rx.sv | 57 +++++
 tb/tb_toggle_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared constants for the toggle event receiver.
// Latency constants cover both builds, with and without TOGGLE_RX_SYNC_EN.
package toggle_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int LAT_NOSYNC = 2;
  localparam int LAT_SYNC   = 3;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/toggle_edge_det.sv
// Sampling chain for the incoming event toggle; det pulses one cycle per level change.
// Define TOGGLE_RX_SYNC_EN to add a metastability flop when the sender is asynchronous.
module toggle_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic req_tgl,
  output logic det
);

  logic req_s;
  logic req_p;

`ifdef TOGGLE_RX_SYNC_EN
  logic req_m;

  // Reset preloads every stage with the live level, so a static input produces no event
  always_ff @(posedge clk) begin
    if (rst) begin
      req_m <= req_tgl;
      req_s <= req_tgl;
      req_p <= req_tgl;
    end else begin
      req_m <= req_tgl;
      req_s <= req_m;
      req_p <= req_s;
    end
  end
`else
  // Reset preloads both stages with the live level, so a static input produces no event
  always_ff @(posedge clk) begin
    if (rst) begin
      req_s <= req_tgl;
      req_p <= req_tgl;
    end else begin
      req_s <= req_tgl;
      req_p <= req_s;
    end
  end
`endif

  assign det = req_s ^ req_p;

endmodule

// File: rtl/toggle_rx.sv
// Toggle-to-handshake receiver: counts detected toggles, serves them on valid/ready, acks by toggling.
// Build option TOGGLE_RX_SYNC_EN adds one input synchroniser stage (see toggle_edge_det).
module toggle_rx
  import toggle_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_tgl,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ack_tgl,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic det;
  logic consume;

  toggle_edge_det u_edge_det (
    .clk     (clk),
    .rst     (rst),
    .req_tgl (req_tgl),
    .det     (det)
  );

  assign consume   = evt_valid && evt_ready;
  assign evt_valid = (pend_cnt != '0);

  // A detect and a consume on the same edge cancel; a detect at full count is dropped and flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt <= '0;
      ack_tgl  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (consume) begin
        ack_tgl <= ~ack_tgl;
      end
      case ({det, consume})
        2'b10: begin
          if (pend_cnt == CNT_MAX) begin
            ovf <= 1'b1;
          end else begin
            pend_cnt <= pend_cnt + CNT_W'(1);
          end
        end
        2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_rx.sv
// Directed bench for toggle_rx: table-driven burst/drain plus hand sequences for latency,
// streaming, saturation and mid-operation reset. Latency follows TOGGLE_RX_SYNC_EN.
module tb_toggle_rx;
  import toggle_pkg::*;

  localparam int CNT_W = CNT_W_DEF;
  localparam int MAXC  = cnt_max(CNT_W);
`ifdef TOGGLE_RX_SYNC_EN
  localparam int LAT = LAT_SYNC;
`else
  localparam int LAT = LAT_NOSYNC;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_tgl;
  logic             evt_ready;
  logic             evt_valid;
  logic [CNT_W-1:0] pend_cnt;
  logic             ack_tgl;
  logic             ovf;

  toggle_rx #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_tgl   (req_tgl),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .pend_cnt  (pend_cnt),
    .ack_tgl   (ack_tgl),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic req;
    logic rdy;
    logic chk;
    int   cnt;
    logic valid;
    logic ack;
    logic ovf;
  } vec_t;

  vec_t tbl[10];
  int   errors = 0;
  int   checks = 0;
  int   flips;
  logic prev_ack;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs, then sample outputs 1 time unit after the next rising edge
  task automatic applyStimulus(input logic r, input logic rdy);
    req_tgl   = r;
    evt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input int cnt, input int valid,
                            input int ack, input int ov);
    checkOutput({tag, " pend_cnt"}, int'(pend_cnt), cnt);
    checkOutput({tag, " evt_valid"}, int'(evt_valid), valid);
    checkOutput({tag, " ack_tgl"}, int'(ack_tgl), ack);
    checkOutput({tag, " ovf"}, int'(ovf), ov);
  endtask

  initial begin
    tbl[0] = '{req:1'b1, rdy:1'b0, chk:1'b0, cnt:0, valid:1'b0, ack:1'b1, ovf:1'b0};
    tbl[1] = '{req:1'b0, rdy:1'b0, chk:1'b0, cnt:0, valid:1'b0, ack:1'b1, ovf:1'b0};
    tbl[2] = '{req:1'b1, rdy:1'b0, chk:1'b0, cnt:0, valid:1'b0, ack:1'b1, ovf:1'b0};
    tbl[3] = '{req:1'b1, rdy:1'b0, chk:1'b0, cnt:0, valid:1'b0, ack:1'b1, ovf:1'b0};
    tbl[4] = '{req:1'b1, rdy:1'b0, chk:1'b1, cnt:3, valid:1'b1, ack:1'b1, ovf:1'b0};
    tbl[5] = '{req:1'b1, rdy:1'b1, chk:1'b1, cnt:2, valid:1'b1, ack:1'b0, ovf:1'b0};
    tbl[6] = '{req:1'b1, rdy:1'b1, chk:1'b1, cnt:1, valid:1'b1, ack:1'b1, ovf:1'b0};
    tbl[7] = '{req:1'b1, rdy:1'b1, chk:1'b1, cnt:0, valid:1'b0, ack:1'b0, ovf:1'b0};
    tbl[8] = '{req:1'b1, rdy:1'b0, chk:1'b1, cnt:0, valid:1'b0, ack:1'b0, ovf:1'b0};
    tbl[9] = '{req:1'b1, rdy:1'b1, chk:1'b1, cnt:0, valid:1'b0, ack:1'b0, ovf:1'b0};

    // Reset with req_tgl high, then hold it static
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    rst = 1'b0;
    checkState("reset", 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("static%0d pend_cnt", i), int'(pend_cnt), 0);
      checkOutput($sformatf("static%0d evt_valid", i), int'(evt_valid), 0);
      checkOutput($sformatf("static%0d ack_tgl", i), int'(ack_tgl), 0);
    end

    // Single toggle latency
    for (int i = 1; i <= LAT; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("lat step%0d pend_cnt", i), int'(pend_cnt), (i == LAT) ? 1 : 0);
      checkOutput($sformatf("lat step%0d evt_valid", i), int'(evt_valid), (i == LAT) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b1);
    checkState("single consume", 0, 0, 1, 0);
    applyStimulus(1'b0, 1'b1);
    checkState("ready while empty", 0, 0, 1, 0);

    // Burst of three toggles then drain, from the table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].req, tbl[i].rdy);
      if (tbl[i].chk) begin
        checkState($sformatf("row%0d", i), tbl[i].cnt, int'(tbl[i].valid),
                   int'(tbl[i].ack), int'(tbl[i].ovf));
      end
    end

    // Toggle every cycle with ready held high
    flips    = 0;
    prev_ack = ack_tgl;
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(~req_tgl, 1'b1);
      if (ack_tgl != prev_ack) flips++;
      prev_ack = ack_tgl;
      if (j >= LAT) checkOutput($sformatf("stream%0d pend_cnt", j), int'(pend_cnt), 1);
    end
    for (int j = 0; j < 6; j++) begin
      applyStimulus(req_tgl, 1'b1);
      if (ack_tgl != prev_ack) flips++;
      prev_ack = ack_tgl;
    end
    checkOutput("stream ack flips", flips, 8);
    checkState("stream drained", 0, 0, 0, 0);

    // Fill to the maximum count without overflow
    for (int j = 0; j < MAXC; j++) applyStimulus(~req_tgl, 1'b0);
    for (int j = 0; j < LAT; j++) applyStimulus(req_tgl, 1'b0);
    checkState("full", MAXC, 1, 0, 0);

    // Detect and consume on the same edge at full count
    applyStimulus(~req_tgl, 1'b0);
    for (int j = 0; j < LAT - 2; j++) applyStimulus(req_tgl, 1'b0);
    applyStimulus(req_tgl, 1'b1);
    checkState("full det+consume", MAXC, 1, 1, 0);

    // One more event at full count is dropped
    applyStimulus(~req_tgl, 1'b0);
    for (int j = 0; j < LAT; j++) applyStimulus(req_tgl, 1'b0);
    checkState("overflow", MAXC, 1, 1, 1);
    for (int j = 0; j < MAXC; j++) applyStimulus(req_tgl, 1'b1);
    checkState("overflow drained", 0, 0, 0, 1);

    // Reset with events pending
    for (int j = 0; j < 6; j++) applyStimulus(~req_tgl, 1'b0);
    for (int j = 0; j < LAT; j++) applyStimulus(req_tgl, 1'b0);
    applyStimulus(req_tgl, 1'b1);
    checkState("pending five", 5, 1, 1, 1);
    rst = 1'b1;
    applyStimulus(req_tgl, 1'b0);
    rst = 1'b0;
    checkState("mid reset", 0, 0, 0, 0);
    for (int j = 0; j < LAT + 3; j++) begin
      applyStimulus(req_tgl, 1'b0);
      checkOutput($sformatf("post reset%0d pend_cnt", j), int'(pend_cnt), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
